// File: rtl/fwd_lookup.sv
// L2 forwarding stage: learns SA->port bindings in a direct-mapped flop table,
// looks up the DA and returns a destination port mask; stale entries age out.
module fwd_lookup #(
    parameter int NUM_PORTS   = 4,
    parameter int PORT_SZ     = 2,
    parameter int TBL_ADDR_SZ = 4,
    parameter int AGE_PERIOD  = 65536
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   c_srdy,
    output logic                   c_drdy,
    input  logic [96+PORT_SZ-1:0]  c_data,
    output logic                   p_srdy,
    input  logic                   p_drdy,
    output logic [NUM_PORTS-1:0]   p_data
);

    localparam int TBL_DEPTH = 1 << TBL_ADDR_SZ;
    localparam int NSLICE    = (48 + TBL_ADDR_SZ - 1) / TBL_ADDR_SZ;
    localparam int PAD_W     = NSLICE * TBL_ADDR_SZ;
    localparam int AGE_W     = (AGE_PERIOD > 1) ? $clog2(AGE_PERIOD) : 1;
    localparam logic [AGE_W-1:0]   AGE_LAST  = AGE_W'(AGE_PERIOD - 1);
    localparam logic [PORT_SZ:0]   SRC_LIMIT = (PORT_SZ+1)'(NUM_PORTS);

    typedef enum logic [1:0] {
        IDLE,
        LEARN,
        LOOKUP,
        OUT
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [PORT_SZ-1:0]     req_src;
    logic [47:0]            req_sa;
    logic [47:0]            req_da;

    logic                   tbl_valid [TBL_DEPTH];
    logic                   tbl_hit   [TBL_DEPTH];
    logic [47:0]            tbl_mac   [TBL_DEPTH];
    logic [PORT_SZ-1:0]     tbl_port  [TBL_DEPTH];

    logic [AGE_W-1:0]       age_cnt;
    logic                   sweep_pending;
    logic                   sweep_now;
    logic                   age_wrap;

    logic [TBL_ADDR_SZ-1:0] sa_hash;
    logic [TBL_ADDR_SZ-1:0] da_hash;
    logic                   src_ok;
    logic                   learn_en;
    logic                   ent_match;
    logic [NUM_PORTS-1:0]   flood_mask;
    logic [NUM_PORTS-1:0]   one_hot;
    logic [NUM_PORTS-1:0]   lookup_mask;

    // XOR-fold of the MAC in TBL_ADDR_SZ-bit slices, last slice zero-padded
    function automatic logic [TBL_ADDR_SZ-1:0] mac_hash(input logic [47:0] mac);
        logic [PAD_W-1:0]       padded;
        logic [TBL_ADDR_SZ-1:0] h;
        padded = PAD_W'(mac);
        h      = '0;
        for (int s = 0; s < NSLICE; s++) begin
            h = h ^ padded[s*TBL_ADDR_SZ +: TBL_ADDR_SZ];
        end
        return h;
    endfunction

    assign c_drdy    = (state == IDLE) && !sweep_pending;
    assign sweep_now = (state == IDLE) && sweep_pending;
    assign age_wrap  = (age_cnt == AGE_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (c_srdy && c_drdy) state_nxt = LEARN;
            LEARN:   state_nxt = LOOKUP;
            LOOKUP:  state_nxt = OUT;
            OUT:     if (p_srdy && p_drdy) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_src <= '0;
            req_sa  <= '0;
            req_da  <= '0;
        end else if (c_srdy && c_drdy) begin
            {req_src, req_sa, req_da} <= c_data;
        end
    end

    // Flooding excludes the ingress port; an out-of-range source floods everywhere
    always_comb begin
        sa_hash     = mac_hash(req_sa);
        da_hash     = mac_hash(req_da);
        src_ok      = ({1'b0, req_src} < SRC_LIMIT);
        learn_en    = (state == LEARN) && !req_sa[40] && src_ok;
        ent_match   = tbl_valid[da_hash] && (tbl_mac[da_hash] == req_da);
        flood_mask  = '0;
        one_hot     = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            flood_mask[i] = (req_src != PORT_SZ'(i));
            one_hot[i]    = (tbl_port[da_hash] == PORT_SZ'(i));
        end
        if (req_da[40] || !ent_match) begin
            lookup_mask = flood_mask;
        end else if (tbl_port[da_hash] == req_src) begin
            lookup_mask = '0;
        end else begin
            lookup_mask = one_hot;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < TBL_DEPTH; i++) begin
                tbl_valid[i] <= 1'b0;
                tbl_hit[i]   <= 1'b0;
                tbl_mac[i]   <= '0;
                tbl_port[i]  <= '0;
            end
        end else if (sweep_now) begin
            for (int i = 0; i < TBL_DEPTH; i++) begin
                tbl_valid[i] <= tbl_valid[i] & tbl_hit[i];
                tbl_hit[i]   <= 1'b0;
            end
        end else if (learn_en) begin
            tbl_valid[sa_hash] <= 1'b1;
            tbl_hit[sa_hash]   <= 1'b1;
            tbl_mac[sa_hash]   <= req_sa;
            tbl_port[sa_hash]  <= req_src;
        end
    end

    // A wrap arriving while a sweep is still pending is absorbed
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            age_cnt       <= '0;
            sweep_pending <= 1'b0;
        end else begin
            age_cnt <= age_wrap ? '0 : age_cnt + AGE_W'(1);
            if (sweep_now) begin
                sweep_pending <= 1'b0;
            end else if (age_wrap) begin
                sweep_pending <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            p_srdy <= 1'b0;
            p_data <= '0;
        end else if (state == LOOKUP) begin
            p_srdy <= 1'b1;
            p_data <= lookup_mask;
        end else if (p_srdy && p_drdy) begin
            p_srdy <= 1'b0;
        end
    end

endmodule
